// File: rtl/tri_scan_ctrl.sv
// Triangle scan controller: walks the bounding box of one triangle in
// row-major order, evaluates the three edge functions with one shared
// evaluator (one edge per cycle) and streams out every inside pixel over a
// valid/ready handshake.
module tri_scan_ctrl (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] v1x,
  input  logic [10:0] v1y,
  input  logic [10:0] v2x,
  input  logic [10:0] v2y,
  input  logic [10:0] v3x,
  input  logic [10:0] v3y,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [22:0] pix_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_E0, S_E1, S_E2, S_EMIT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [10:0] r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
  logic [10:0] r_xmin, r_xmax, r_ymax;
  logic [10:0] r_x, r_y;
  logic        r_e0, r_e1;
  logic [22:0] r_count;

  logic [10:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic [10:0] w_ax, w_ay, w_bx, w_by;
  logic signed [11:0] w_dpx, w_day, w_dax, w_dpy;
  logic signed [23:0] w_lhs, w_rhs;
  logic        w_edge, w_inside, w_last, w_hs;

  function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b,
                                       input logic [10:0] c);
    logic [10:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b,
                                       input logic [10:0] c);
    logic [10:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  assign w_xmin = min3(r_v1x, r_v2x, r_v3x);
  assign w_xmax = max3(r_v1x, r_v2x, r_v3x);
  assign w_ymin = min3(r_v1y, r_v2y, r_v3y);
  assign w_ymax = max3(r_v1y, r_v2y, r_v3y);

  // Select the (A,B) vertex pair for the edge evaluated in the current state.
  always_comb begin
    w_ax = r_v1x; w_ay = r_v1y; w_bx = r_v2x; w_by = r_v2y;
    case (r_state)
      S_E1: begin w_ax = r_v2x; w_ay = r_v2y; w_bx = r_v3x; w_by = r_v3y; end
      S_E2: begin w_ax = r_v3x; w_ay = r_v3y; w_bx = r_v1x; w_by = r_v1y; end
      default: ;
    endcase
  end

  assign w_dpx    = $signed({1'b0, r_x})  - $signed({1'b0, w_bx});
  assign w_day    = $signed({1'b0, w_ay}) - $signed({1'b0, w_by});
  assign w_dax    = $signed({1'b0, w_ax}) - $signed({1'b0, w_bx});
  assign w_dpy    = $signed({1'b0, r_y})  - $signed({1'b0, w_by});
  assign w_lhs    = w_dpx * w_day;
  assign w_rhs    = w_dax * w_dpy;
  assign w_edge   = (w_lhs < w_rhs);
  assign w_inside = (r_e0 == r_e1) && (r_e1 == w_edge);
  assign w_last   = (r_x == r_xmax) && (r_y == r_ymax);
  assign w_hs     = (r_state == S_EMIT) && out_ready;

  // State register.
  always_ff @(posedge CLK) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_BBOX;
      S_BBOX: w_next = S_E0;
      S_E0:   w_next = S_E1;
      S_E1:   w_next = S_E2;
      S_E2: begin
        if (w_inside)    w_next = S_EMIT;
        else if (w_last) w_next = S_DONE;
        else             w_next = S_E0;
      end
      S_EMIT: if (out_ready) w_next = w_last ? S_DONE : S_E0;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: vertex capture, box setup, edge bits, scan position, pixel count.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_v1x <= '0; r_v1y <= '0; r_v2x <= '0; r_v2y <= '0; r_v3x <= '0; r_v3y <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymax <= '0;
      r_x <= '0; r_y <= '0;
      r_e0 <= 1'b0; r_e1 <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_v1x <= v1x; r_v1y <= v1y; r_v2x <= v2x; r_v2y <= v2y;
          r_v3x <= v3x; r_v3y <= v3y;
          r_count <= '0;
        end
        S_BBOX: begin
          r_xmin <= w_xmin; r_xmax <= w_xmax; r_ymax <= w_ymax;
          r_x <= w_xmin; r_y <= w_ymin;
        end
        S_E0: r_e0 <= w_edge;
        S_E1: r_e1 <= w_edge;
        default: ;
      endcase
      if (w_hs) r_count <= r_count + 23'd1;
      // Advance only after an outside verdict or a completed handshake, never past the last pixel.
      if (((r_state == S_E2 && !w_inside) || w_hs) && !w_last) begin
        if (r_x == r_xmax) begin
          r_x <= r_xmin;
          r_y <= r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign pix_valid = (r_state == S_EMIT);
  assign pix_x     = r_x;
  assign pix_y     = r_y;
  assign pix_count = r_count;

endmodule

// File: tb/tb_tri_scan_ctrl.sv
// Directed bench for tri_scan_ctrl: a table of triangle scans with
// hand-computed counts/timings, plus a mid-scan reset sequence.
module tb_tri_scan_ctrl;

  logic        CLK = 1'b0;
  logic        rst, start, out_ready;
  logic [10:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic        busy, done, pix_valid;
  logic [10:0] pix_x, pix_y;
  logic [22:0] pix_count;

  int n_pass  = 0;
  int n_total = 0;

  tri_scan_ctrl dut (
    .CLK(CLK), .rst(rst), .start(start),
    .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
    .out_ready(out_ready), .busy(busy), .done(done), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_count(pix_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int v1x, v1y, v2x, v2y, v3x, v3y;
    bit stall;      // out_ready pattern 0,0,1 per pixel
    bit poke;       // pulse start while busy
    int mode;       // 0: x+y<=10, 1: strict interior of cw triangle, 2: single point
    int xmin, xmax, ymin, ymax;
    int exp_count;
    int exp_first;  // cycle of first pix_valid
    int exp_done;   // cycle of done
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit exp_inside(input int mode, input int x, input int y);
    case (mode)
      0: return (x + y) <= 10;
      1: return (x > 15) && (y > 0) && (x + y < 30);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_case(input vec_t t, input int abort_at);
    int ex[$], ey[$];
    int cyc, idx, first_cyc, done_cyc, stallcnt, n_new;
    for (int y = t.ymin; y <= t.ymax; y++)
      for (int x = t.xmin; x <= t.xmax; x++)
        if (exp_inside(t.mode, x, y)) begin ex.push_back(x); ey.push_back(y); end

    @(negedge CLK);
    v1x = 11'(t.v1x); v1y = 11'(t.v1y); v2x = 11'(t.v2x);
    v2y = 11'(t.v2y); v3x = 11'(t.v3x); v3y = 11'(t.v3y);
    start = 1'b1;
    out_ready = !t.stall;
    cyc = 0; idx = 0; first_cyc = -1; done_cyc = -1; stallcnt = 0; n_new = 0;

    while (cyc < 5000 && done_cyc < 0) begin
      @(negedge CLK);
      cyc++;
      start = t.poke && (cyc == 20 || cyc == 150);
      if (cyc == 1) begin
        v1x = 11'd2047; v1y = 11'd3; v2x = 11'd700; v2y = 11'd1999; v3x = 11'd1; v3y = 11'd1024;
        chk("busy_after_start", int'(busy), 1);
        chk("count_cleared", int'(pix_count), 0);
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_low_in_done", int'(busy), 0);
      end
      if (pix_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stallcnt == 0) n_new++;
        if (abort_at > 0 && n_new == abort_at) begin
          rst = 1'b0;
          out_ready = 1'b1;
          @(negedge CLK);
          chk("rst_busy", int'(busy), 0);
          chk("rst_done", int'(done), 0);
          chk("rst_valid", int'(pix_valid), 0);
          chk("rst_xy", int'({pix_x, pix_y}), 0);
          chk("rst_count", int'(pix_count), 0);
          rst = 1'b1;
          n_new = 0;
          for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (done || busy) n_new++;
          end
          chk("no_done_after_rst", n_new, 0);
          return;
        end
        if (idx < ex.size()) begin
          chk(stallcnt != 0 ? "stall_hold_x" : "pix_x", int'(pix_x), ex[idx]);
          chk(stallcnt != 0 ? "stall_hold_y" : "pix_y", int'(pix_y), ey[idx]);
        end else begin
          chk("extra_pixel", idx, ex.size() - 1);
        end
        out_ready = t.stall ? (stallcnt == 2) : 1'b1;
        if (out_ready) begin idx++; stallcnt = 0; end
        else stallcnt++;
      end else begin
        out_ready = !t.stall;
      end
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, t.exp_done);
    chk("first_cycle", first_cyc, t.exp_first);
    chk("emitted", idx, t.exp_count);
    chk("pix_count", int'(pix_count), t.exp_count);
    @(negedge CLK);
    chk("done_one_cycle", int'(done), 0);
    chk("count_holds", int'(pix_count), t.exp_count);
  endtask

  initial begin
    tbl[0] = '{0,0, 10,0, 0,10,   0, 0, 0,  0,10, 0,10,  66,  5, 431};
    tbl[1] = '{15,15, 30,0, 15,0, 0, 0, 1, 15,30, 0,15,  91, 56, 861};
    tbl[2] = '{5,5, 5,5, 5,5,     0, 0, 2,  5, 5, 5, 5,   1,  5,   6};
    tbl[3] = '{0,0, 10,0, 0,10,   1, 0, 0,  0,10, 0,10,  66,  5, 563};
    tbl[4] = '{0,0, 10,0, 0,10,   0, 1, 0,  0,10, 0,10,  66,  5, 431};

    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    v1x = '0; v1y = '0; v2x = '0; v2y = '0; v3x = '0; v3y = '0;
    repeat (3) @(negedge CLK);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_valid", int'(pix_valid), 0);
    chk("init_xy", int'({pix_x, pix_y}), 0);
    chk("init_count", int'(pix_count), 0);
    rst = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) run_case(tbl[i], 0);
    run_case(tbl[0], 10);
    run_case(tbl[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
